// File: rtl/bram_snapshot_writer_pkg.sv
// Shared types and helpers for the BRAM snapshot writer: FSM state encoding
// and the capture-length mapping (a programmed length of 0 means full depth).
package bram_snapshot_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Widest BRAM address supported by len_eff; the length needs one extra bit.
    localparam int unsigned MAX_ADDR_WIDTH = 16;
    localparam int unsigned LEN_W          = MAX_ADDR_WIDTH + 1;

    // Effective window length: 0 selects the whole buffer (2**addr_width).
    function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] len,
                                                 input int unsigned     addr_width);
        if (len == '0) begin
            return LEN_W'(1) << addr_width;
        end
        return len;
    endfunction

endpackage

// File: rtl/bram_snapshot_writer.sv
// Trigger-centred capture engine writing a sample stream into a circular BRAM
// buffer. Keeps a programmable number of pre-trigger samples and reports where
// the window starts and where the trigger sample landed.
module bram_snapshot_writer
    import bram_snapshot_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  fpga_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] capture_len,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  armed,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [ADDR_WIDTH-1:0] p_q, p_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   post_q, post_d;

    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  bram_we_q, bram_we_d;
    logic                  armed_q, armed_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;

    logic [ADDR_WIDTH:0]   len_arm;
    logic [ADDR_WIDTH:0]   len_arm_m1;
    logic [ADDR_WIDTH:0]   pretrig_wide;
    logic [ADDR_WIDTH-1:0] p_arm;
    logic [ADDR_WIDTH:0]   post_trig;
    logic                  accept;

    // Arm-time parameters: effective length and pre-trigger depth clamped to L-1.
    always_comb begin
        len_arm      = (ADDR_WIDTH+1)'(len_eff(LEN_W'(capture_len), ADDR_WIDTH));
        len_arm_m1   = len_arm - (ADDR_WIDTH+1)'(1);
        pretrig_wide = {1'b0, pretrig};
        p_arm        = (pretrig_wide > len_arm_m1) ? len_arm_m1[ADDR_WIDTH-1:0] : pretrig;
        post_trig    = len_q - {1'b0, p_q} - (ADDR_WIDTH+1)'(1);
        accept       = (state_q == ST_ARMED) && din_valid && trigger && (pcnt_q == p_q);
    end

    // Next-state, counter and registered-output logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        pcnt_d       = pcnt_q;
        p_d          = p_q;
        len_d        = len_q;
        post_d       = post_q;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        bram_we_d    = 1'b0;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        len_d   = len_arm;
                        p_d     = p_arm;
                        wptr_d  = '0;
                        pcnt_d  = '0;
                    end
                end
                ST_ARMED: begin
                    if (din_valid) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = wptr_q;
                        bram_din_d  = din;
                        wptr_d      = wptr_q + ADDR_WIDTH'(1);
                        if (accept) begin
                            trig_addr_d  = wptr_q;
                            start_addr_d = wptr_q - p_q;
                            post_d       = post_trig;
                            state_d      = (post_trig == '0) ? ST_DONE : ST_CAPTURE;
                        end else if (pcnt_q != p_q) begin
                            pcnt_d = pcnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (din_valid) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = wptr_q;
                        bram_din_d  = din;
                        wptr_d      = wptr_q + ADDR_WIDTH'(1);
                        post_d      = post_q - (ADDR_WIDTH+1)'(1);
                        if (post_q == (ADDR_WIDTH+1)'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Status flags are decoded from the next state so they line up with
        // the write that causes the transition (done coincides with the last write).
        armed_d = (state_d == ST_ARMED);
        busy_d  = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d  = (state_d == ST_DONE);
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            pcnt_q       <= '0;
            p_q          <= '0;
            len_q        <= '0;
            post_q       <= '0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            bram_we_q    <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            pcnt_q       <= pcnt_d;
            p_q          <= p_d;
            len_q        <= len_d;
            post_q       <= post_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            bram_we_q    <= bram_we_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign bram_we    = bram_we_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = start_addr_q;

endmodule

// File: tb/tb_bram_snapshot_writer.sv
// Directed self-checking bench for bram_snapshot_writer (ADDR_WIDTH=4, DEPTH=16).
module tb_bram_snapshot_writer;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          fpga_clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          arm;
    logic          abort;
    logic          trigger;
    logic [AW-1:0] capture_len;
    logic [AW-1:0] pretrig;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          armed;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [16];
    int            wr_total = 0;

    bram_snapshot_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .fpga_clk    (fpga_clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .arm         (arm),
        .abort       (abort),
        .trigger     (trigger),
        .capture_len (capture_len),
        .pretrig     (pretrig),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .armed       (armed),
        .busy        (busy),
        .done        (done),
        .trig_addr   (trig_addr),
        .start_addr  (start_addr)
    );

    always #5 fpga_clk = ~fpga_clk;

    // BRAM model: record every write the DUT presents.
    always @(posedge fpga_clk) begin
        if (bram_we) begin
            mem[bram_addr] <= bram_din;
            wr_total++;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic t);
        din_valid = v;
        din       = d;
        trigger   = t;
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic do_arm(input logic [AW-1:0] len, input logic [AW-1:0] pt);
        capture_len = len;
        pretrig     = pt;
        arm         = 1'b1;
        din_valid   = 1'b0;
        trigger     = 1'b0;
        @(posedge fpga_clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+DW+3+AW+AW-1:0] outs;
        rst = 1'b1; din = '0; din_valid = 0; arm = 0; abort = 0; trigger = 0;
        capture_len = '0; pretrig = '0;
        #1 rst = 1'b0;
        @(posedge fpga_clk); @(posedge fpga_clk); #1;
        outs = {bram_addr, bram_din, bram_we, armed, busy, done, trig_addr, start_addr};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_values: got %0h expected 0", outs);
        end
        rst = 1'b1;
        @(posedge fpga_clk); #1;
    endtask

    task automatic test_basic();
        do_arm(4'd8, 4'd3);
        checks++;
        if ({armed, busy, done} !== 3'b110) begin
            errors++; $display("FAIL basic_armed_flags: got %b expected 110", {armed, busy, done});
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, DW'(i), i == 5);
            checks++;
            if (i <= 9) begin
                if ({bram_we, bram_addr, bram_din} !== {1'b1, AW'(i), DW'(i)}) begin
                    errors++; $display("FAIL basic_write[%0d]: got we=%b a=%0d d=%0d expected we=1 a=%0d d=%0d",
                                       i, bram_we, bram_addr, bram_din, i, i);
                end
            end else if (bram_we !== 1'b0) begin
                errors++; $display("FAIL basic_no_write[%0d]: got we=%b expected 0", i, bram_we);
            end
            checks++;
            if (done !== (i >= 9)) begin
                errors++; $display("FAIL basic_done[%0d]: got %b expected %b", i, done, i >= 9);
            end
        end
        checks++;
        if ({trig_addr, start_addr} !== {4'd5, 4'd2}) begin
            errors++; $display("FAIL basic_addrs: got trig=%0d start=%0d expected 5 2", trig_addr, start_addr);
        end
        for (int k = 2; k <= 9; k++) begin
            checks++;
            if (mem[k] !== DW'(k)) begin
                errors++; $display("FAIL basic_mem[%0d]: got %0d expected %0d", k, mem[k], k);
            end
        end
    endtask

    task automatic test_early_trigger();
        do_arm(4'd8, 4'd3);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(200 + i), (i == 1) || (i == 4));
            if (i == 1) begin
                checks++;
                if ({armed, busy} !== 2'b11) begin
                    errors++; $display("FAIL early_ignored: got armed=%b busy=%b expected 1 1", armed, busy);
                end
            end
            checks++;
            if (done !== (i >= 8)) begin
                errors++; $display("FAIL early_done[%0d]: got %b expected %b", i, done, i >= 8);
            end
        end
        checks++;
        if ({trig_addr, start_addr} !== {4'd4, 4'd1}) begin
            errors++; $display("FAIL early_addrs: got trig=%0d start=%0d expected 4 1", trig_addr, start_addr);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (mem[k] !== DW'(200 + k)) begin
                errors++; $display("FAIL early_mem[%0d]: got %0d expected %0d", k, mem[k], 200 + k);
            end
        end
    endtask

    task automatic test_wrap();
        do_arm(4'd0, 4'd4);
        for (int i = 0; i < 34; i++) begin
            step(1'b1, DW'(300 + i), (i == 2) || (i == 20));
            checks++;
            if (bram_we !== (i <= 31)) begin
                errors++; $display("FAIL wrap_we[%0d]: got %b expected %b", i, bram_we, i <= 31);
            end
        end
        checks++;
        if ({trig_addr, start_addr, done} !== {4'd4, 4'd0, 1'b1}) begin
            errors++; $display("FAIL wrap_addrs: got trig=%0d start=%0d done=%b expected 4 0 1",
                               trig_addr, start_addr, done);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (mem[k] !== DW'(316 + k)) begin
                errors++; $display("FAIL wrap_mem[%0d]: got %0d expected %0d", k, mem[k], 316 + k);
            end
        end
    endtask

    task automatic test_gapped();
        int w0;
        do_arm(4'd4, 4'd0);
        w0 = wr_total;
        for (int c = 0; c < 10; c++) begin
            logic v;
            v = (c % 2) == 0;
            step(v, DW'(400 + c), c == 0);
            checks++;
            if (v && c <= 6) begin
                if ({bram_we, bram_addr, bram_din} !== {1'b1, AW'(c / 2), DW'(400 + c)}) begin
                    errors++; $display("FAIL gap_write[%0d]: got we=%b a=%0d d=%0d expected we=1 a=%0d d=%0d",
                                       c, bram_we, bram_addr, bram_din, c / 2, 400 + c);
                end
            end else if (bram_we !== 1'b0) begin
                errors++; $display("FAIL gap_idle[%0d]: got we=%b expected 0", c, bram_we);
            end
        end
        checks++;
        if (wr_total - w0 !== 4) begin
            errors++; $display("FAIL gap_count: got %0d expected 4", wr_total - w0);
        end
        checks++;
        if ({trig_addr, start_addr, done} !== {4'd0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL gap_addrs: got trig=%0d start=%0d done=%b expected 0 0 1",
                               trig_addr, start_addr, done);
        end
    endtask

    task automatic test_abort();
        do_arm(4'd8, 4'd2);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(500 + i), i == 2);
        checks++;
        if ({busy, armed} !== 2'b10) begin
            errors++; $display("FAIL abort_in_capture: got busy=%b armed=%b expected 1 0", busy, armed);
        end
        abort = 1'b1;
        step(1'b1, DW'(505), 1'b0);
        abort = 1'b0;
        checks++;
        if ({bram_we, busy, done, armed} !== 4'b0000) begin
            errors++; $display("FAIL abort_flags: got we/busy/done/armed=%b expected 0000",
                               {bram_we, busy, done, armed});
        end
        checks++;
        if ({trig_addr, start_addr} !== {4'd2, 4'd0}) begin
            errors++; $display("FAIL abort_hold: got trig=%0d start=%0d expected 2 0", trig_addr, start_addr);
        end
        do_arm(4'd4, 4'd0);
        step(1'b1, DW'(600), 1'b1);
        checks++;
        if ({bram_we, bram_addr, bram_din, trig_addr} !== {1'b1, 4'd0, DW'(600), 4'd0}) begin
            errors++; $display("FAIL abort_rearm: got we=%b a=%0d d=%0d trig=%0d expected 1 0 600 0",
                               bram_we, bram_addr, bram_din, trig_addr);
        end
        for (int i = 1; i < 4; i++) step(1'b1, DW'(600 + i), 1'b0);
        checks++;
        if ({bram_addr, done} !== {4'd3, 1'b1}) begin
            errors++; $display("FAIL abort_rearm_done: got a=%0d done=%b expected 3 1", bram_addr, done);
        end
    endtask

    task automatic test_clamp();
        do_arm(4'd8, 4'd9);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, DW'(700 + i), i == 7);
            checks++;
            if ({bram_we, done} !== {i <= 7, i >= 7}) begin
                errors++; $display("FAIL clamp_seq[%0d]: got we=%b done=%b expected %b %b",
                                   i, bram_we, done, i <= 7, i >= 7);
            end
        end
        checks++;
        if ({trig_addr, start_addr} !== {4'd7, 4'd0}) begin
            errors++; $display("FAIL clamp_addrs: got trig=%0d start=%0d expected 7 0", trig_addr, start_addr);
        end
    endtask

    task automatic test_async_reset();
        logic [AW+DW+3+AW+AW-1:0] outs;
        do_arm(4'd8, 4'd0);
        step(1'b1, DW'(800), 1'b1);
        step(1'b1, DW'(801), 1'b0);
        checks++;
        if ({busy, bram_we} !== 2'b11) begin
            errors++; $display("FAIL areset_pre: got busy=%b we=%b expected 1 1", busy, bram_we);
        end
        #2 rst = 1'b0;
        #1;
        outs = {bram_addr, bram_din, bram_we, armed, busy, done, trig_addr, start_addr};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL areset_values: got %0h expected 0", outs);
        end
        din_valid = 1'b0;
        @(posedge fpga_clk); #1;
        rst = 1'b1;
        step(1'b1, DW'(802), 1'b1);
        checks++;
        if ({bram_we, armed, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL areset_idle: got we/armed/busy/done=%b expected 0000",
                               {bram_we, armed, busy, done});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_trigger();
        test_wrap();
        test_gapped();
        test_abort();
        test_clamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
